switch_debounce_select: RTL and testbench

- Upstream conditioning stage for the Go Board switch-driven datapath.
- Takes the raw mechanical switches i_Switch_1/i_Switch_2 and synchronises and debounces each one.
- Outputs a clean 2-bit select bus plus one-cycle edge strobes, so downstream select logic (mux, LED display) sees glitch-free values.
- A select-change strobe lets consumers register or count selection events.

---
 rtl/switch_debounce_select_pkg.sv | 19 +
 rtl/switch_debounce_select_debounce_filter.sv | 66 ++++++
 rtl/switch_debounce_select.sv | 66 ++++++
 tb/tb_switch_debounce_select.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_debounce_select_pkg.sv
// Shared constants for the switch conditioning path: clock rate, debounce time
// and the select encoding reused by the downstream mux.
package switch_debounce_select_pkg;

  localparam int unsigned CLK_FREQ_HZ = 25_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // Stable cycles needed before a new switch level is accepted.
  localparam int unsigned DEBOUNCE_LIMIT_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  localparam int unsigned SEL_W = 2;
  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_0 = 2'b00;
  localparam sel_t SEL_1 = 2'b01;
  localparam sel_t SEL_2 = 2'b10;
  localparam sel_t SEL_3 = 2'b11;

endpackage

// File: rtl/switch_debounce_select_debounce_filter.sv
// Single-channel switch conditioner: 2-flop synchroniser, stability counter,
// accepted level register and registered rise/fall strobes.
module switch_debounce_select_debounce_filter
  import switch_debounce_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Raw,
  output logic o_Stable,
  output logic o_Rise,
  output logic o_Fall,
  output logic o_Accept_c
);

  localparam int unsigned COUNT_W = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(DEBOUNCE_LIMIT - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_stable;
  logic [COUNT_W-1:0] r_count;
  logic               r_rise;
  logic               r_fall;
  logic               w_accept;

  // Synchronised level has differed from the accepted one for the full window.
  always_comb begin
    w_accept = 1'b0;
    if ((r_sync2 != r_stable) && (r_count == COUNT_MAX)) begin
      w_accept = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_count  <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1 <= i_Raw;
      r_sync2 <= r_sync1;
      r_rise  <= w_accept & r_sync2;
      r_fall  <= w_accept & ~r_sync2;
      // Any return to the accepted level restarts qualification from zero.
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_count  <= '0;
      end else begin
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign o_Stable   = r_stable;
  assign o_Rise     = r_rise;
  assign o_Fall     = r_fall;
  assign o_Accept_c = w_accept;

endmodule

// File: rtl/switch_debounce_select.sv
// Two-switch conditioning stage: debounced select bus, per-switch edge strobes
// and a single select-change strobe for downstream consumers.
module switch_debounce_select
  import switch_debounce_select_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [1:0] o_Select,
  output logic       o_Sw1_Rise,
  output logic       o_Sw1_Fall,
  output logic       o_Sw2_Rise,
  output logic       o_Sw2_Fall,
  output logic       o_Sel_Change
);

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("switch_debounce_select: DEBOUNCE_LIMIT must be at least 2");
  end

  logic w_stable_1;
  logic w_stable_2;
  logic w_accept_1;
  logic w_accept_2;
  logic r_sel_change;

  switch_debounce_select_debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_filter_1 (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Raw      (i_Switch_1),
    .o_Stable   (w_stable_1),
    .o_Rise     (o_Sw1_Rise),
    .o_Fall     (o_Sw1_Fall),
    .o_Accept_c (w_accept_1)
  );

  switch_debounce_select_debounce_filter #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_filter_2 (
    .i_Clk      (i_Clk),
    .i_Rst_L    (i_Rst_L),
    .i_Raw      (i_Switch_2),
    .o_Stable   (w_stable_2),
    .o_Rise     (o_Sw2_Rise),
    .o_Fall     (o_Sw2_Fall),
    .o_Accept_c (w_accept_2)
  );

  // Registered alongside the channel strobes so all pulses share one edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_sel_change <= 1'b0;
    end else begin
      r_sel_change <= w_accept_1 | w_accept_2;
    end
  end

  assign o_Select     = {w_stable_2, w_stable_1};
  assign o_Sel_Change = r_sel_change;

endmodule

// File: tb/tb_switch_debounce_select.sv
// Bench for switch_debounce_select: a short-window instance and a long-window
// instance share the switch inputs and are checked against a window model.
module tb_switch_debounce_select;

  localparam int L_A  = 4;
  localparam int L_B  = 64;
  localparam int HIST = 8192;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1   = 1'b1;
  logic       sw2   = 1'b1;
  logic [1:0] sel_a, sel_b;
  logic       r1a, f1a, r2a, f2a, ca;
  logic       r1b, f1b, r2b, f2b, cb;
  logic [4:0] strb_a, strb_b;

  always #5 clk = ~clk;

  switch_debounce_select #(.DEBOUNCE_LIMIT(L_A)) u_dut_a (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Select(sel_a), .o_Sw1_Rise(r1a), .o_Sw1_Fall(f1a),
    .o_Sw2_Rise(r2a), .o_Sw2_Fall(f2a), .o_Sel_Change(ca)
  );

  switch_debounce_select #(.DEBOUNCE_LIMIT(L_B)) u_dut_b (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Switch_1(sw1), .i_Switch_2(sw2),
    .o_Select(sel_b), .o_Sw1_Rise(r1b), .o_Sw1_Fall(f1b),
    .o_Sw2_Rise(r2b), .o_Sw2_Fall(f2b), .o_Sel_Change(cb)
  );

  assign strb_a = {r1a, f1a, r2a, f2a, ca};
  assign strb_b = {r1b, f1b, r2b, f2b, cb};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: channel 0/1 = dut_a sw1/sw2, channel 2/3 = dut_b sw1/sw2.
  // A level is accepted when the last LIMIT synchronised samples (raw delayed
  // by two edges) all differ from the currently accepted level.
  bit mh[4][HIST];
  bit ms[4];
  bit mr[4];
  bit mf[4];
  bit mc[2];
  int m_n = 0;

  function automatic int lim(input int ch);
    return (ch < 2) ? L_A : L_B;
  endfunction

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0;
        for (int ch = 0; ch < 4; ch++) begin
          ms[ch] = 1'b0; mr[ch] = 1'b0; mf[ch] = 1'b0;
        end
        mc[0] = 1'b0; mc[1] = 1'b0;
      end else begin
        for (int ch = 0; ch < 4; ch++) mh[ch][m_n % HIST] = (ch % 2 == 0) ? sw1 : sw2;
        mc[0] = 1'b0; mc[1] = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
          bit acc;
          acc = 1'b1;
          for (int j = 0; j < lim(ch); j++) begin
            int idx;
            bit s;
            idx = m_n - 2 - j;
            s = (idx < 0) ? 1'b0 : mh[ch][idx % HIST];
            if (s == ms[ch]) acc = 1'b0;
          end
          mr[ch] = acc && !ms[ch];
          mf[ch] = acc && ms[ch];
          if (acc) ms[ch] = !ms[ch];
          mc[ch / 2] = mc[ch / 2] | acc;
        end
        m_n++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_a", 32'({sel_a, strb_a}), 32'({ms[1], ms[0], mr[0], mf[0], mr[1], mf[1], mc[0]}));
    chk("model_b", 32'({sel_b, strb_b}), 32'({ms[3], ms[2], mr[2], mf[2], mr[3], mf[3], mc[1]}));
  end

  task automatic drive(input logic s1, input logic s2);
    @(negedge clk);
    sw1 = s1;
    sw2 = s2;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold sw1 high for len cycles on the long-window instance.
  task automatic big_pulse(input int len, input bit accept);
    @(negedge clk);
    sw1 = 1'b1;
    for (int k = 0; k <= L_B + 3; k++) begin
      @(negedge clk);
      if (k == len - 1) sw1 = 1'b0;
      if (k == L_B) chk("big_pre", 32'(sel_b[0]), 32'(0));
      if (k == L_B + 1) chk("big_edge", 32'({sel_b[0], r1b}), accept ? 32'(3) : 32'(0));
    end
    wait_n(L_B + 10);
  endtask

  initial begin : stim
    // Reset held with both switches high.
    wait_n(3);
    chk("reset_hold_sel_a", 32'(sel_a), 32'(0));
    chk("reset_hold_strb_a", 32'(strb_a), 32'(0));
    chk("reset_hold_sel_b", 32'(sel_b), 32'(0));
    @(negedge clk);
    rst_n = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
    wait_n(10);
    chk("idle_sel", 32'(sel_a), 32'(0));

    // Clean press on switch 1.
    drive(1'b1, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) chk("press_early", 32'({sel_a, strb_a}), 32'(0));
      if (k == 5) chk("press_edge", 32'({sel_a, strb_a}), 32'({2'b01, 5'b10001}));
      if (k == 6) chk("press_after", 32'({sel_a, strb_a}), 32'({2'b01, 5'b00000}));
    end
    drive(1'b0, 1'b0);
    wait_n(10);

    // Bounce rejection on switch 2.
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      chk("bounce_sel1", 32'(sel_a[1]), 32'(0));
      chk("bounce_strb", 32'(strb_a), 32'(0));
      sw2 = (i < 4) && (i % 2 == 0);
    end

    // Bounce then settle high on switch 2.
    drive(1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk); sw2 = 1'b0;
    @(negedge clk); sw2 = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk("settle_sel1", 32'(sel_a[1]), 32'(k >= L_A + 1));
      chk("settle_rise2", 32'({r2a, ca}), (k == L_A + 1) ? 32'(3) : 32'(0));
    end
    drive(1'b0, 1'b0);
    wait_n(10);

    // Both switches rise together.
    drive(1'b1, 1'b1);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      if (k == L_A) chk("simul_pre", 32'(sel_a), 32'(0));
      if (k == L_A + 1) chk("simul_edge", 32'({sel_a, strb_a}), 32'({2'b11, 5'b10101}));
      if (k == L_A + 2) chk("simul_after", 32'({sel_a, strb_a}), 32'({2'b11, 5'b00000}));
    end
    drive(1'b0, 1'b0);
    wait_n(10);

    // Reset mid-count: qualification restarts from zero after release.
    drive(1'b1, 1'b0);
    wait_n(4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= L_A + 2; k++) begin
      @(negedge clk);
      chk("rst_mid_sel", 32'(sel_a), 32'(k >= L_A + 1));
      chk("rst_mid_rise", 32'(strb_a), (k == L_A + 1) ? 32'(5'b10001) : 32'(0));
    end
    drive(1'b0, 1'b0);
    for (int k = 0; k <= L_A + 2; k++) begin
      @(negedge clk);
      chk("fall_sel", 32'(sel_a), 32'(k < L_A + 1));
      chk("fall_strb", 32'(strb_a), (k == L_A + 1) ? 32'(5'b01001) : 32'(0));
    end
    wait_n(10);

    // Long window: one cycle short is rejected, exact length is accepted.
    big_pulse(L_B - 1, 1'b0);
    big_pulse(L_B, 1'b1);

    // Randomised mix of bounces, short holds and long holds.
    for (int seg = 0; seg < 300; seg++) begin
      int r;
      int len;
      r = int'($urandom_range(0, 9));
      if (r < 4) len = 1;
      else if (r < 8) len = int'($urandom_range(2, 10));
      else len = int'($urandom_range(L_B - 2, L_B + 6));
      sw1 = 1'($urandom_range(0, 1));
      sw2 = 1'($urandom_range(0, 1));
      wait_n(len);
    end

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    drive(1'b1, 1'b1);
    wait_n(L_B + 10);
    chk("pre_rst_sel_a", 32'(sel_a), 32'(3));
    chk("pre_rst_sel_b", 32'(sel_b), 32'(3));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sel_a", 32'(sel_a), 32'(0));
    chk("async_rst_sel_b", 32'(sel_b), 32'(0));
    chk("async_rst_strb", 32'({strb_a, strb_b}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(L_B + 10);
    chk("requal_sel_b", 32'(sel_b), 32'(3));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
